// File: rtl/cdm_pipe_mult.sv
// Pipelined carry-disregard multiplier W x W -> 2W; mode_i picks per-column mod-256 (0) or exact (1).
// Latency 3 cycles, 1/cycle, up to 3 in flight; a stage holds while its successor is full and stalled.
// Define CDM_ERRMON_EN to add err_o / err_cnt_o, the error against the exact product.
module cdm_pipe_mult #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           mode_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] r_o,
`ifdef CDM_ERRMON_EN
  output logic [2*W-1:0] err_o,
  output logic [15:0]    err_cnt_o,
`endif
  output logic           mode_o
);
  localparam int N  = W / 8;
  localparam int C  = 2 * N;
  localparam int CW = 8 + $clog2(C);
  localparam int RW = 2 * W;

  logic          v1_q, v2_q, m1_q, m2_q;
  logic          load1, load2, load3;
  logic [15:0]   pp_q  [N*N];
  logic [CW-1:0] col_d [C];
  logic [CW-1:0] col_q [C];
  logic [RW-1:0] exact_d, cd_d, r_d;

  assign load3    = !out_valid || out_ready;
  assign load2    = !v2_q || load3;
  assign load1    = !v1_q || load2;
  assign in_ready = load1;

  // S1: exact 8x8 digit products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      m1_q <= 1'b0;
      for (int p = 0; p < N*N; p++) pp_q[p] <= '0;
    end else if (load1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        m1_q <= mode_i;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            pp_q[i*N+j] <= 16'(a_i[8*i +: 8]) * 16'(b_i[8*j +: 8]);
      end
    end
  end

  // Low byte of pp[i][j] lands in column i+j, high byte in column i+j+1.
  always_comb begin
    for (int k = 0; k < C; k++) col_d[k] = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        col_d[i+j]   = col_d[i+j]   + CW'(pp_q[i*N+j][7:0]);
        col_d[i+j+1] = col_d[i+j+1] + CW'(pp_q[i*N+j][15:8]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0;
      m2_q <= 1'b0;
      for (int k = 0; k < C; k++) col_q[k] <= '0;
    end else if (load2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        m2_q <= m1_q;
        for (int k = 0; k < C; k++) col_q[k] <= col_d[k];
      end
    end
  end

  // S3: either keep each column's low byte or propagate carries for the exact product.
  always_comb begin
    exact_d = '0;
    cd_d    = '0;
    for (int k = 0; k < C; k++) begin
      exact_d         = exact_d + (RW'(col_q[k]) << (8*k));
      cd_d[8*k +: 8]  = col_q[k][7:0];
    end
    r_d = m2_q ? exact_d : cd_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      r_o       <= '0;
      mode_o    <= 1'b0;
    end else if (load3) begin
      out_valid <= v2_q;
      if (v2_q) begin
        r_o    <= r_d;
        mode_o <= m2_q;
      end
    end
  end

`ifdef CDM_ERRMON_EN
  logic [RW-1:0] err_d;
  assign err_d = exact_d - r_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o     <= '0;
      err_cnt_o <= '0;
    end else begin
      if (load3 && v2_q) err_o <= err_d;
      if (out_valid && out_ready && err_o != '0 && err_cnt_o != 16'hFFFF)
        err_cnt_o <= err_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdm_pipe_mult.sv
// Self-checking bench for cdm_pipe_mult (W=16): scoreboard of model results checked on every delivery.
`timescale 1ns/1ps
module tb_cdm_pipe_mult;
  localparam int W  = 16;
  localparam int N  = W / 8;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          mode_i = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] r_o;
  logic          mode_o;
`ifdef CDM_ERRMON_EN
  logic [RW-1:0] err_o;
  logic [15:0]   err_cnt_o;
`endif

  always #5 clk = ~clk;

  cdm_pipe_mult #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .mode_i    (mode_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_o       (r_o),
`ifdef CDM_ERRMON_EN
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o),
`endif
    .mode_o    (mode_o)
  );

  typedef struct packed {
    logic [RW-1:0] r;
    logic [RW-1:0] ex;
    logic          m;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   rnd_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic logic [RW-1:0] exact(input logic [W-1:0] a, input logic [W-1:0] b);
    return RW'(a) * RW'(b);
  endfunction

  // Byte k of the carry-disregard result: all digit-product bytes landing in column k, mod 256.
  function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    logic [RW-1:0] r;
    int s, p;
    r = '0;
    if (m) return exact(a, b);
    for (int k = 0; k < 2*N; k++) begin
      s = 0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          p = int'(a[8*i +: 8]) * int'(b[8*j +: 8]);
          if (i + j == k)     s += p % 256;
          if (i + j + 1 == k) s += p / 256;
        end
      end
      r[8*k +: 8] = 8'(s % 256);
    end
    return r;
  endfunction

  // Acceptance monitor: inputs are stable at the falling edge, transfer happens on the next rising edge.
  exp_t acc;
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      acc.r  = model(a_i, b_i, mode_i);
      acc.ex = exact(a_i, b_i);
      acc.m  = mode_i;
      sb.push_back(acc);
    end
  end

  // Delivery checker plus hold-while-stalled checks.
  exp_t          e;
  bit            stall_q = 1'b0;
  logic [RW-1:0] held_r;
  logic          held_m;
  int            cnt_m = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
      cnt_m   = 0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_r", 64'(r_o), 64'(held_r));
        check("hold_mode", 64'(mode_o), 64'(held_m));
      end
`ifdef CDM_ERRMON_EN
      check("err_cnt", 64'(err_cnt_o), 64'(cnt_m));
`endif
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("result", 64'(r_o), 64'(e.r));
          check("mode", 64'(mode_o), 64'(e.m));
          if (!e.m) check("cdm_le_exact", 64'(r_o <= e.ex), 64'd1);
`ifdef CDM_ERRMON_EN
          check("err_o", 64'(err_o), 64'(e.ex - e.r));
          if (e.ex != e.r && cnt_m != 65535) cnt_m++;
`endif
        end
      end
      stall_q = out_valid && !out_ready;
      held_r  = r_o;
      held_m  = mode_o;
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the operands.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    a_i = a;
    b_i = b;
    mode_i = m;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (sb.size() != 0 || out_valid); t++) @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [W-1:0] dir_a [10] = '{16'hFFFF, 16'hFFFF, 16'h0180, 16'h0180, 16'h0100,
                               16'h0100, 16'h00FF, 16'h00FF, 16'h1234, 16'h0000};
  logic [W-1:0] dir_b [10] = '{16'hFFFF, 16'hFFFF, 16'h0180, 16'h0180, 16'h0100,
                               16'h0100, 16'h00FF, 16'h00FF, 16'h5678, 16'hBEEF};
  logic         dir_m [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_r_o", 64'(r_o), 64'd0);
    check("rst_mode_o", 64'(mode_o), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    check("model_ffff_m0", 64'(model(16'hFFFF, 16'hFFFF, 1'b0)), 64'h0000_0000_FEFD_0001);
    check("model_ffff_m1", 64'(model(16'hFFFF, 16'hFFFF, 1'b1)), 64'h0000_0000_FFFE_0001);
    check("model_0180_m0", 64'(model(16'h0180, 16'h0180, 1'b0)), 64'h0000_0000_0001_4000);
    check("model_0180_m1", 64'(model(16'h0180, 16'h0180, 1'b1)), 64'h0000_0000_0002_4000);
    check("model_0100_m0", 64'(model(16'h0100, 16'h0100, 1'b0)), 64'h0000_0000_0001_0000);
    check("model_00ff_m0", 64'(model(16'h00FF, 16'h00FF, 1'b0)), 64'h0000_0000_0000_FE01);

    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors back-to-back, mixed modes.
    for (int v = 0; v < 10; v++) send(dir_a[v], dir_b[v], dir_m[v]);
    idle();
    drain();

    // Full pipeline under backpressure: three accepted, fourth refused until release.
    out_ready = 1'b0;
    send(16'h0003, 16'h0005, 1'b0);
    send(16'h0102, 16'h0304, 1'b1);
    send(16'hABCD, 16'h1234, 1'b0);
    in_valid = 1'b1; a_i = 16'hFFFF; b_i = 16'h0101; mode_i = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
    end
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_first_r", 64'(r_o), 64'h0000_0000_0000_000F);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("run_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1 idle();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("run_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    drain();

    // Reset with two transactions in flight.
    send(16'h1111, 16'h2222, 1'b1);
    send(16'h3333, 16'h4444, 1'b0);
    idle();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_r_o", 64'(r_o), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      check("no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Random operands, modes and consumer backpressure.
    rnd_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h0000;
        default: ra = W'($urandom);
      endcase
      rb = W'($urandom);
      send(ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end
    end
    idle();
    rnd_rdy = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
